// File: rtl/count_chk_jk_if.sv
// count_chk_jk_if: count-stream bus between a counter under test (master)
// and the count_chk_jk sequence checker (slave).
interface count_chk_jk_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0] count;
  logic             valid;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [WIDTH-1:0] expected;
  logic [ERR_W-1:0] err_cnt;

  // Counter side: produces the stream, observes the checker status.
  modport master (
    output count, valid,
    input  locked, err, wrap, expected, err_cnt
  );

  // Checker side: samples the stream, reports status.
  modport slave (
    input  count, valid,
    output locked, err, wrap, expected, err_cnt
  );
endinterface

// File: rtl/count_chk_jk.sv
// count_chk_jk: receive-side checker for the JK counter family.
// Locks onto a modulo-2^WIDTH increment sequence after 1+LOCK_CNT clean
// samples, then flags sequence errors (err), legal max->0 steps (wrap) and
// keeps a saturating error tally. All outputs are registered.
// Optional feature macro: COUNT_CHK_HOLD_EN -- when defined, a repeated value
// (counter enable low) is legal while locked and neutral while syncing.
module count_chk_jk #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  count_chk_jk_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  // Saturating increment of the error tally.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_W'(1'b1);
    end
    return r;
  endfunction

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] prev_r, prev_nx_s;
  logic [3:0]       good_run_r, good_run_nx_s;
  logic             locked_r, err_r, wrap_r;
  logic             err_nx_s, wrap_nx_s;
  logic [WIDTH-1:0] expected_r, expected_nx_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_nx_s;

  logic [WIDTH-1:0] succ_s;
  logic             is_succ_s;
  logic             hold_ok_s;

  assign succ_s    = prev_r + CNT_ONE;
  assign is_succ_s = (bus.count == succ_s);

`ifdef COUNT_CHK_HOLD_EN
  assign hold_ok_s = (bus.count == prev_r);
`else
  assign hold_ok_s = 1'b0;
`endif

  // Next-state, next-prev, run counter and status pulse decode.
  always_comb begin
    state_nx_s    = state_r;
    prev_nx_s     = prev_r;
    good_run_nx_s = good_run_r;
    err_nx_s      = 1'b0;
    wrap_nx_s     = 1'b0;
    err_cnt_nx_s  = err_cnt_r;
    if (bus.valid) begin
      case (state_r)
        ST_IDLE: begin
          prev_nx_s     = bus.count;
          good_run_nx_s = 4'd0;
          state_nx_s    = ST_SYNC;
        end
        ST_SYNC: begin
          prev_nx_s = bus.count;
          if (is_succ_s) begin
            good_run_nx_s = good_run_r + 4'd1;
            if ((good_run_r + 4'd1) == LOCK_TGT) begin
              state_nx_s = ST_LOCKED;
            end else begin
              state_nx_s = ST_SYNC;
            end
          end else if (hold_ok_s) begin
            good_run_nx_s = good_run_r;
          end else begin
            good_run_nx_s = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (is_succ_s) begin
            prev_nx_s = bus.count;
            wrap_nx_s = (prev_r == CNT_MAX) && (bus.count == CNT_ZERO);
          end else if (hold_ok_s) begin
            prev_nx_s = prev_r;
          end else begin
            err_nx_s      = 1'b1;
            err_cnt_nx_s  = sat_inc(err_cnt_r);
            state_nx_s    = ST_SYNC;
            good_run_nx_s = 4'd0;
            prev_nx_s     = bus.count;
          end
        end
        default: begin
          state_nx_s    = ST_IDLE;
          prev_nx_s     = CNT_ZERO;
          good_run_nx_s = 4'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Registered view of the next expected value; zero while idle.
  always_comb begin
    if (state_nx_s == ST_IDLE) begin
      expected_nx_s = CNT_ZERO;
    end else begin
      expected_nx_s = prev_nx_s + CNT_ONE;
    end
  end

  // State and registered outputs; reset forces IDLE and cancels pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      prev_r     <= CNT_ZERO;
      good_run_r <= 4'd0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      wrap_r     <= 1'b0;
      expected_r <= CNT_ZERO;
      err_cnt_r  <= ERR_ZERO;
    end else begin
      state_r    <= state_nx_s;
      prev_r     <= prev_nx_s;
      good_run_r <= good_run_nx_s;
      locked_r   <= (state_nx_s == ST_LOCKED);
      err_r      <= err_nx_s;
      wrap_r     <= wrap_nx_s;
      expected_r <= expected_nx_s;
      err_cnt_r  <= err_cnt_nx_s;
    end
  end

  assign bus.locked   = locked_r;
  assign bus.err      = err_r;
  assign bus.wrap     = wrap_r;
  assign bus.expected = expected_r;
  assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_count_chk_jk.sv
// tb_count_chk_jk: directed plus randomized stimulus for count_chk_jk, checked
// against a behavioural model. Two instances run in parallel on the same
// stream: default ERR_W=8 and ERR_W=4 (saturation at 15).
module tb_count_chk_jk;

  localparam int W  = 3;
  localparam int N  = 8;   // 2**W
  localparam int LC = 2;

  logic clk;
  logic rst;

  count_chk_jk_if #(.WIDTH(W), .ERR_W(8)) bus_a ();
  count_chk_jk_if #(.WIDTH(W), .ERR_W(4)) bus_b ();

  count_chk_jk #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  count_chk_jk #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: mode 0 idle, 1 syncing, 2 locked.
  int m_mode, m_last, m_run, m_errs;
  bit m_err, m_wrap;

`ifdef COUNT_CHK_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_run = 0; m_errs = 0;
    m_err = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit v, input int c);
    m_err  = 1'b0;
    m_wrap = 1'b0;
    if (v) begin
      if (m_mode == 0) begin
        m_last = c; m_run = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (c == (m_last + 1) % N) begin
          m_run = m_run + 1;
          if (m_run == LC) m_mode = 2;
        end else if (!(HOLD && c == m_last)) begin
          m_run = 0;
        end
        m_last = c;
      end else begin
        if (c == (m_last + 1) % N) begin
          m_wrap = (m_last == N - 1) && (c == 0);
          m_last = c;
        end else if (!(HOLD && c == m_last)) begin
          m_err = 1'b1; m_errs++; m_mode = 1; m_run = 0; m_last = c;
        end
      end
    end
  endtask

  function automatic int m_expected();
    return (m_mode == 0) ? 0 : (m_last + 1) % N;
  endfunction

  task automatic check_all();
    chk_eq("locked_a",   int'(bus_a.locked),   int'(m_mode == 2));
    chk_eq("err_a",      int'(bus_a.err),      int'(m_err));
    chk_eq("wrap_a",     int'(bus_a.wrap),     int'(m_wrap));
    chk_eq("expected_a", int'(bus_a.expected), m_expected());
    chk_eq("err_cnt_a",  int'(bus_a.err_cnt),  (m_errs > 255) ? 255 : m_errs);
    chk_eq("locked_b",   int'(bus_b.locked),   int'(m_mode == 2));
    chk_eq("err_b",      int'(bus_b.err),      int'(m_err));
    chk_eq("wrap_b",     int'(bus_b.wrap),     int'(m_wrap));
    chk_eq("expected_b", int'(bus_b.expected), m_expected());
    chk_eq("err_cnt_b",  int'(bus_b.err_cnt),  (m_errs > 15) ? 15 : m_errs);
  endtask

  // One clock: drive, sample edge, update model, check #1 after the edge.
  task automatic cycle(input bit v, input int c);
    bus_a.valid = v; bus_a.count = W'(c);
    bus_b.valid = v; bus_b.count = W'(c);
    @(posedge clk);
    if (!rst) model_reset();
    else model_step(v, c);
    #1;
    check_all();
  endtask

  // Feed successors until locked (bounded), then one bad value.
  task automatic lock_then_bad();
    for (int k = 0; k < 12 && m_mode != 2; k++) cycle(1'b1, (m_last + 1) % N);
    chk_eq("lock_reached", m_mode, 2);
    cycle(1'b1, (m_last + 3) % N);
  endtask

  initial begin
    bit v;
    int c, r;
    model_reset();
    rst = 1'b1;
    bus_a.valid = 1'b0; bus_a.count = '0;
    bus_b.valid = 1'b0; bus_b.count = '0;
    #2 rst = 1'b0;
    #1 check_all();
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    rst = 1'b1;

    // Basic lock and wrap: 0..7,0
    for (int i = 0; i <= 8; i++) begin
      cycle(1'b1, i % N);
      if (i == 2) begin
        chk_eq("lock_at_2", int'(bus_a.locked), 1);
        chk_eq("exp_at_2", int'(bus_a.expected), 3);
      end
      if (i == 8) chk_eq("wrap_after_7", int'(bus_a.wrap), 1);
    end

    // Error and relock: 1,2,3 then 5,6,7
    cycle(1'b1, 1); cycle(1'b1, 2); cycle(1'b1, 3);
    cycle(1'b1, 5);
    chk_eq("err_on_5", int'(bus_a.err), 1);
    chk_eq("err_cnt_1", int'(bus_a.err_cnt), 1);
    cycle(1'b1, 6);
    cycle(1'b1, 7);
    chk_eq("relock_at_7", int'(bus_a.locked), 1);

    // Hold: 0,1,2,3 then 4,4,5
    for (int i = 0; i < 4; i++) cycle(1'b1, i);
    cycle(1'b1, 4);
    cycle(1'b1, 4);
    chk_eq("hold_err", int'(bus_a.err), HOLD ? 0 : 1);
    cycle(1'b1, 5);
    cycle(1'b1, 6);
    // Walk to expected=6 while locked
    for (int i = 0; i < 7; i++) cycle(1'b1, (7 + i) % N);
    chk_eq("pre_gap_exp", int'(bus_a.expected), 6);

    // Valid gap with junk counts, then 6
    cycle(1'b0, 1); cycle(1'b0, 3); cycle(1'b0, 2);
    cycle(1'b1, 6);
    chk_eq("gap_accept", int'(bus_a.locked), 1);

    // Bring error tally to 2 while locked
    if (m_errs < 2) lock_then_bad();
    for (int k = 0; k < 12 && m_mode != 2; k++) cycle(1'b1, (m_last + 1) % N);
    chk_eq("pre_rst_errs", int'(bus_a.err_cnt), 2);

    // Async reset between edges
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_eq("arst_locked", int'(bus_a.locked), 0);
    chk_eq("arst_err_cnt", int'(bus_a.err_cnt), 0);
    chk_eq("arst_expected", int'(bus_a.expected), 0);
    check_all();
    @(negedge clk);
    cycle(1'b1, 4);
    rst = 1'b1;

    // Saturation: 20 lock-then-bad rounds
    for (int i = 0; i < 20; i++) begin
      lock_then_bad();
      chk_eq("sat_err_pulse", int'(bus_b.err), 1);
    end
    chk_eq("sat_err_cnt_b", int'(bus_b.err_cnt), 15);

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       c = (m_last + 1) % N;
      else if (r == 7) c = m_last;
      else             c = $urandom_range(0, N - 1);
      cycle(v, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/count_chk_jk.md
# count_chk_jk

Receive-side checker for the JK flip-flop counter family. It samples the WIDTH-bit count stream produced by a counter such as the 3-bit JK up-counter and locks onto the legal increment sequence. Once locked, it flags sequence errors, reports wrap-around, and keeps a saturating error tally. It sits downstream of the counter under test, either in silicon self-check logic or as a bench monitor.

## Interface
- WIDTH, 3: width of the observed count.
- LOCK_CNT, 2: consecutive legal increments required to enter LOCKED (1..15).
- ERR_W, 8: width of the saturating error counter.

- clk  in  1  rising-edge clock, shared with the counter.
- rst  in  1  reset; asynchronous, active-low.
- count  in  WIDTH  observed counter value.
- valid  in  1  count is sampled on a rising clk edge only when valid=1.
- locked  out  1  high while FSM is in LOCKED.
- err  out  1  one-cycle pulse on a sequence error detected in LOCKED.
- wrap  out  1  one-cycle pulse on a legal max→0 step in LOCKED.
- expected  out  WIDTH  next legal value, (prev+1) mod 2^WIDTH; 0 in IDLE.
- err_cnt  out  ERR_W  saturating count of err pulses.

## Operation
- Internal registers: state (IDLE/SYNC/LOCKED), prev[WIDTH], good_run[4].
- All outputs are registered.
- valid=0: all state holds, and err/wrap are 0 that cycle. count is don't-care.
- IDLE, valid=1: prev←count, good_run←0, go to SYNC. No err.
- SYNC, valid=1, count==prev+1 (mod 2^WIDTH):
  - good_run←good_run+1.
  - If the new good_run == LOCK_CNT, go to LOCKED.
- SYNC, valid=1, other values: good_run←0, stay in SYNC, no err pulse.
- SYNC, prev update: prev←count on every valid sample.
- LOCKED, count==expected:
  - Stay in LOCKED, prev←count.
  - wrap=1 if prev==2^WIDTH−1 and count==0.
- LOCKED, mismatch:
  - err=1 for one cycle.
  - err_cnt←err_cnt+1, saturating at 2^ERR_W−1.
  - state←SYNC, good_run←0, prev←count (resync on the bad value).
- Arithmetic: the increment is modulo 2^WIDTH. The comparison is full-width equality.
- err_cnt is never cleared except by rst.

## Timing
- Reset (rst=0), applied asynchronously:
  - state=IDLE, prev=0, good_run=0.
  - locked=0, err=0, wrap=0, expected=0, err_cnt=0.
- Deassertion is sampled at the next rising edge. The first valid sample may occur on that edge.
- Latency: a sample taken at edge N produces err/wrap/locked/expected/err_cnt values at edge N. They are visible during cycle N→N+1.
- err and wrap are never asserted together.
- Lock time from IDLE with a clean stream is 1+LOCK_CNT valid samples.
- Reset mid-operation forces IDLE immediately. A pulse in flight is cancelled.

## Configuration
- COUNT_CHK_HOLD_EN defined:
  - In LOCKED, count==prev is legal (counter enable low).
  - No err, prev unchanged, expected unchanged, wrap=0.
  - In SYNC, a repeat leaves good_run unchanged.
- COUNT_CHK_HOLD_EN undefined: a repeated value is a mismatch, handled per the rules above.

## Test plan
- Basic lock and wrap (LOCK_CNT=2):
  - Stimulus: rst low 2 cycles, then count 0,1,2,…,7,0 with valid=1 every cycle.
  - Response: locked=1 at the edge sampling 2; expected=3 at that edge; wrap pulses once at the edge sampling the 0 after 7; err never asserts.
- Error and relock:
  - Stimulus: after lock at 3, inject 5, then 6,7.
  - Response: err pulses at the edge sampling 5; err_cnt=1; locked=0; locked=1 again at the edge sampling 7.
- Hold feature:
  - Stimulus: after lock, apply 4,4,5.
  - Response without macro: err at the second 4, err_cnt+1.
  - Response with COUNT_CHK_HOLD_EN: no err, expected stays 5, 5 accepted.
- Valid gaps:
  - Stimulus: when locked with expected=6, drop valid for 3 cycles while count shows 1,3,2; then valid=1 with count=6.
  - Response: no err and no state change during the gap; 6 is accepted.
- Async reset mid-stream:
  - Stimulus: assert rst=0 between edges while locked with err_cnt=2.
  - Response: locked, err_cnt and expected go to 0 without waiting for a clock edge.
- Saturation:
  - Stimulus: ERR_W=4; repeat 20 cycles of lock followed by a bad value.
  - Response: err_cnt stops at 15, and err still pulses each time.
